// File: rtl/selftest_uart_reporter.sv
// selftest_uart_reporter
//
// Periodically reports the self-test master's error count over a UART TX
// line as the ASCII string "E=XXXX\r\n" (4 upper-case hex digits), 8N1,
// LSB first. The first report starts REPORT_CYCLES clocks after reset
// release, and further reports follow every REPORT_CYCLES clocks.
//
// Build option:
//   ERR_TRIGGER_EN  when defined, an error pulse also requests a report.
//                   It does not restart the period counter. When undefined,
//                   the error input is ignored.
//
// Parameters:
//   CLK_DIV        clocks per UART bit (>= 2)
//   REPORT_CYCLES  clocks between periodic reports (> 80*CLK_DIV)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   error      one-cycle mismatch pulse from the self-test master
//   error_cnt  running mismatch count (16 bits)
//   uart_tx    serial output, idle high
//   busy       high while a message is being shifted out
module selftest_uart_reporter #(
  parameter int CLK_DIV       = 434,
  parameter int REPORT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        error,
  input  logic [15:0] error_cnt,
  output logic        uart_tx,
  output logic        busy
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int PW = $clog2(REPORT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      char_idx_q, char_idx_d;
  logic [15:0]     snap_q, snap_d;
  logic            pending_q, pending_d;
  logic [PW-1:0]   period_q, period_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;

  logic            trig_period;
  logic            err_trig;
  logic            trig;
  logic            bit_done;
  logic            start_msg;
  logic [7:0]      cur_char;

`ifdef ERR_TRIGGER_EN
  assign err_trig = error;
`else
  // The error input has no function in this build.
  logic unused_error;
  assign unused_error = error;
  assign err_trig     = 1'b0;
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};  // 'A' + (n - 10)
  endfunction

  always_comb begin
    cur_char = 8'h00;
    case (char_idx_q)
      3'd0:    cur_char = 8'h45;
      3'd1:    cur_char = 8'h3D;
      3'd2:    cur_char = hex_ascii(snap_q[15:12]);
      3'd3:    cur_char = hex_ascii(snap_q[11:8]);
      3'd4:    cur_char = hex_ascii(snap_q[7:4]);
      3'd5:    cur_char = hex_ascii(snap_q[3:0]);
      3'd6:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  assign trig_period = (period_q == PW'(REPORT_CYCLES - 1));
  assign trig        = trig_period | err_trig;
  assign bit_done    = (bit_cnt_q == BW'(CLK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    snap_d     = snap_q;
    pending_d  = pending_q;
    start_msg  = 1'b0;
    tx_d       = 1'b1;
    busy_d     = 1'b0;

    period_d = trig_period ? '0 : period_q + 1'b1;

    if (state_q != S_IDLE) begin
      bit_cnt_d = bit_done ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q || trig) start_msg = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      default: begin  // S_STOP
        if (bit_done) begin
          if (char_idx_q == 3'd7) begin
            // A queued request restarts straight from the stop bit so the
            // next message follows with no idle gap.
            if (pending_q || trig) start_msg = 1'b1;
            else                   state_d   = S_IDLE;
          end else begin
            char_idx_d = char_idx_q + 3'd1;
            state_d    = S_START;
          end
        end
      end
    endcase

    // Starting a message consumes the request; a trigger that does not
    // start a message is merged into the single pending flag.
    if (start_msg) begin
      state_d    = S_START;
      snap_d     = error_cnt;
      char_idx_d = 3'd0;
      bit_cnt_d  = '0;
      pending_d  = 1'b0;
    end else if (trig) begin
      pending_d = 1'b1;
    end

    // Outputs are registered from the next state so the line is glitch-free.
    // Entering DATA never changes char_idx or snapshot, so cur_char is valid.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_char[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      snap_q     <= '0;
      pending_q  <= 1'b0;
      period_q   <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      snap_q     <= snap_d;
      pending_q  <= pending_d;
      period_q   <= period_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_selftest_uart_reporter.sv
// Testbench for selftest_uart_reporter (CLK_DIV=4, REPORT_CYCLES=400).
// A message-level reference model predicts the line level and busy for each
// cycle. A UART receiver decodes the line, and the decoded bytes are
// compared against the expected message text.
module tb_selftest_uart_reporter;

  localparam int DIV = 4;
  localparam int PER = 400;
  localparam int MSG = 80 * DIV;

  logic        clk;
  logic        rst;
  logic        error;
  logic [15:0] error_cnt;
  logic        uart_tx;
  logic        busy;

  selftest_uart_reporter #(
    .CLK_DIV      (DIV),
    .REPORT_CYCLES(PER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .error    (error),
    .error_cnt(error_cnt),
    .uart_tx  (uart_tx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          c;         // cycles since reset release
  int          m_start;   // start cycle of the current message, -1 if none
  logic [15:0] m_val;
  bit          m_pend;
  logic [7:0]  exp_q[$];

  // receiver state
  bit          rx_on;
  int          rx_t;
  logic [7:0]  rx_byte;
  logic [7:0]  rx_log[$];
  int          first_fall;

  // waveform comparison
  int          wave_bad;
  int          wave_first;
  int          busy_cnt;
  bit          count_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] v, input int idx);
    logic [3:0] n;
    case (idx)
      0: return 8'h45;
      1: return 8'h3D;
      6: return 8'h0D;
      7: return 8'h0A;
      default: begin
        n = v[15 - 4 * (idx - 2) -: 4];
        if (n < 10) return 8'h30 + {4'h0, n};
        else        return 8'h41 + {4'h0, n} - 8'd10;
      end
    endcase
  endfunction

  task automatic model_reset();
    c          = 0;
    m_start    = -1;
    m_pend     = 1'b0;
    m_val      = '0;
    exp_q.delete();
    rx_on      = 1'b0;
    rx_t       = 0;
    first_fall = -1;
  endtask

  // One clock: compare outputs for cycle c, run the receiver, advance the
  // model with the inputs of cycle c, then move to the next cycle.
  task automatic step();
    bit         active, fin, trig, e_tx;
    int         t, b;
    logic [7:0] ch;
    active = (m_start >= 0) && (c >= m_start) && (c - m_start < MSG);
    e_tx   = 1'b1;
    if (active) begin
      t  = c - m_start;
      ch = exp_byte(m_val, t / (10 * DIV));
      b  = (t % (10 * DIV)) / DIV;
      if (b == 0)      e_tx = 1'b0;
      else if (b == 9) e_tx = 1'b1;
      else             e_tx = ch[b - 1];
    end
    if (uart_tx !== e_tx || busy !== active) begin
      if (wave_bad == 0) wave_first = c;
      wave_bad++;
    end
    if (count_busy && busy === 1'b1) busy_cnt++;

    // UART receiver sampling mid-bit
    if (!rx_on) begin
      if (uart_tx === 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
        if (first_fall < 0) first_fall = c;
      end
    end else begin
      rx_t++;
      if (rx_t >= DIV + DIV / 2 && rx_t <= 8 * DIV + DIV / 2 && (rx_t % DIV) == DIV / 2)
        rx_byte[(rx_t - DIV - DIV / 2) / DIV] = uart_tx;
      if (rx_t == 9 * DIV + DIV / 2) begin
        chk("stop_bit", {31'd0, uart_tx}, 32'd1);
        chk("rx_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          $display("byte %0d at cycle %0d: got %02h exp %02h", rx_log.size(), c, rx_byte, exp_q[0]);
          chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
        rx_log.push_back(rx_byte);
      end
      if (rx_t == 10 * DIV - 1) rx_on = 1'b0;
    end

    // message-level model
    trig = ((c % PER) == PER - 1);
`ifdef ERR_TRIGGER_EN
    trig = trig || (error === 1'b1);
`endif
    fin = active && (c - m_start == MSG - 1);
    if ((!active || fin) && (m_pend || trig)) begin
      m_start = c + 1;
      m_val   = error_cnt;
      m_pend  = 1'b0;
      for (int i = 0; i < 8; i++) exp_q.push_back(exp_byte(error_cnt, i));
    end else begin
      if (fin)  m_start = -1;
      if (trig) m_pend  = 1'b1;
    end

    @(posedge clk);
    #1;
    error = 1'b0;
    c++;
  endtask

  task automatic run_to(input int target);
    while (c < target) step();
  endtask

  logic [7:0] s1 [8];
  logic [7:0] s2 [8];
  logic [7:0] s3 [8];
  int         guard;

  initial begin
    s1 = '{8'h45, 8'h3D, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    s2 = '{8'h45, 8'h3D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    s3 = '{8'h45, 8'h3D, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    wave_bad   = 0;
    wave_first = -1;
    busy_cnt   = 0;
    count_busy = 1'b0;
    rst        = 1'b1;
    error      = 1'b0;
    error_cnt  = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // 1: first periodic message with a fixed count
    error_cnt  = 16'h1A2F;
    count_busy = 1'b1;
    run_to(720);
    error_cnt = 16'h0000;
    run_to(800);
    count_busy = 1'b0;
    chk("first_start", first_fall, 32'd400);
    chk("busy_len", busy_cnt, MSG);
    chk("msg1_len", rx_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("msg1_char%0d", i), {24'd0, rx_log[i]}, {24'd0, s1[i]});

    // 2: count changes mid-message and must not leak into the text
    run_to(900);
    error_cnt = 16'hFFFF;
    run_to(1560);
    chk("msg23_len", rx_log.size(), 32'd24);
    for (int i = 0; i < 8; i++) chk($sformatf("msg2_char%0d", i), {24'd0, rx_log[8 + i]}, {24'd0, s2[i]});
    for (int i = 0; i < 8; i++) chk($sformatf("msg3_char%0d", i), {24'd0, rx_log[16 + i]}, {24'd0, s3[i]});
    chk("wave_s12", wave_bad, 32'd0);

    // 3: asynchronous reset in the middle of a message
    error_cnt = 16'h5A5A;
    run_to(1750);
    chk("busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_tx", {31'd0, uart_tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_to(400);
    chk("quiet_after_rst", first_fall, 32'hFFFF_FFFF);
    run_to(401);
    chk("restart_start", first_fall, 32'd400);
    chk("wave_s3", wave_bad, 32'd0);

    // randomized counts and error pulses against the reference model
    for (int i = 0; i < 6 * PER; i++) begin
      if ($urandom_range(7) == 0)  error_cnt = 16'($urandom);
      if ($urandom_range(59) == 0) error = 1'b1;
      step();
    end
    guard = 0;
    while ((m_start >= 0 || m_pend) && guard < 4 * PER) begin
      step();
      guard++;
    end
    chk("drain_bound", {31'd0, guard < 4 * PER}, 32'd1);
    chk("bytes_left", exp_q.size(), 32'd0);
    chk($sformatf("wave_final_first@%0d", wave_first), wave_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
